// File: rtl/csr_trap_sequencer.sv
// Sequences machine-mode trap/interrupt entry and mret exit: latches commit-time state,
// issues the CSR write burst, then a one-cycle fetch redirect.
module csr_trap_sequencer #(
  parameter int unsigned CSR_ADDR_WIDTH = 12,
  parameter int unsigned REG_DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      commit_trap_req,
  input  logic [REG_DATA_WIDTH-1:0] commit_trap_cause,
  input  logic [REG_DATA_WIDTH-1:0] commit_trap_pc,
  input  logic [REG_DATA_WIDTH-1:0] commit_trap_tval,
  input  logic                      commit_mret_req,
  input  logic                      commit_int_allow,
  input  logic [REG_DATA_WIDTH-1:0] commit_int_pc,
  input  logic [REG_DATA_WIDTH-1:0] csrf_all_mie_data,
  input  logic [REG_DATA_WIDTH-1:0] csrf_all_mip_data,
  input  logic [REG_DATA_WIDTH-1:0] csrf_all_mstatus_data,
  input  logic [REG_DATA_WIDTH-1:0] csrf_all_mepc_data,
  output logic [CSR_ADDR_WIDTH-1:0] trap_csrf_read_addr,
  input  logic [REG_DATA_WIDTH-1:0] csrf_trap_read_data,
  output logic [CSR_ADDR_WIDTH-1:0] trap_csrf_write_addr,
  output logic [REG_DATA_WIDTH-1:0] trap_csrf_write_data,
  output logic                      trap_csrf_we,
  output logic                      trap_commit_busy,
  output logic                      trap_fetch_jump,
  output logic [REG_DATA_WIDTH-1:0] trap_fetch_jump_pc
);
  localparam int unsigned W = REG_DATA_WIDTH;

  typedef enum logic [2:0] {
    IDLE, W_MEPC, W_MCAUSE, W_MTVAL, W_MSTATUS, R_MSTATUS, JUMP
  } state_e;

  state_e       state_q, state_d;
  logic [W-1:0] epc_q, epc_d, cause_q, cause_d, tval_q, tval_d;
  logic [W-1:0] mtvec_q, mtvec_d, mstatus_q, mstatus_d;
  logic [3:0]   code_q, code_d;
  logic         int_q, int_d, mret_q, mret_d;

  logic [W-1:0] irq_bits;
  logic         irq_pending;
  logic [3:0]   irq_code;
  logic [W-1:0] mtvec_base;

  assign trap_csrf_read_addr = CSR_ADDR_WIDTH'(12'h305);
  assign trap_commit_busy    = (state_q != IDLE);
  assign mtvec_base          = {mtvec_q[W-1:2], 2'b00};

  always_comb begin
    irq_bits    = csrf_all_mie_data & csrf_all_mip_data & W'(12'h888);
    irq_pending = commit_int_allow && csrf_all_mstatus_data[3] && (|irq_bits);
    // MEI beats MSI beats MTI
    if (irq_bits[11])     irq_code = 4'd11;
    else if (irq_bits[3]) irq_code = 4'd3;
    else                  irq_code = 4'd7;
  end

  always_comb begin
    state_d              = state_q;
    epc_d                = epc_q;
    cause_d              = cause_q;
    tval_d               = tval_q;
    mtvec_d              = mtvec_q;
    mstatus_d            = mstatus_q;
    code_d               = code_q;
    int_d                = int_q;
    mret_d               = mret_q;
    trap_csrf_we         = 1'b0;
    trap_csrf_write_addr = '0;
    trap_csrf_write_data = '0;
    trap_fetch_jump      = 1'b0;
    trap_fetch_jump_pc   = '0;
    case (state_q)
      IDLE: begin
        if (commit_trap_req) begin
          epc_d     = commit_trap_pc;
          cause_d   = commit_trap_cause;
          tval_d    = commit_trap_tval;
          mtvec_d   = csrf_trap_read_data;
          mstatus_d = csrf_all_mstatus_data;
          code_d    = '0;
          int_d     = 1'b0;
          mret_d    = 1'b0;
          state_d   = W_MEPC;
        end else if (irq_pending) begin
          epc_d     = commit_int_pc;
          cause_d   = {1'b1, (W-1)'(irq_code)};
          tval_d    = '0;
          mtvec_d   = csrf_trap_read_data;
          mstatus_d = csrf_all_mstatus_data;
          code_d    = irq_code;
          int_d     = 1'b1;
          mret_d    = 1'b0;
          state_d   = W_MEPC;
        end else if (commit_mret_req) begin
          int_d   = 1'b0;
          mret_d  = 1'b1;
          state_d = R_MSTATUS;
        end
      end
      W_MEPC: begin
        trap_csrf_we         = 1'b1;
        trap_csrf_write_addr = CSR_ADDR_WIDTH'(12'h341);
        trap_csrf_write_data = epc_q;
        state_d              = W_MCAUSE;
      end
      W_MCAUSE: begin
        trap_csrf_we         = 1'b1;
        trap_csrf_write_addr = CSR_ADDR_WIDTH'(12'h342);
        trap_csrf_write_data = cause_q;
        state_d              = W_MTVAL;
      end
      W_MTVAL: begin
        trap_csrf_we         = 1'b1;
        trap_csrf_write_addr = CSR_ADDR_WIDTH'(12'h343);
        trap_csrf_write_data = tval_q;
        state_d              = W_MSTATUS;
      end
      W_MSTATUS: begin
        trap_csrf_we                = 1'b1;
        trap_csrf_write_addr        = CSR_ADDR_WIDTH'(12'h300);
        trap_csrf_write_data        = mstatus_q;
        trap_csrf_write_data[7]     = mstatus_q[3];
        trap_csrf_write_data[3]     = 1'b0;
        trap_csrf_write_data[12:11] = 2'b11;
        state_d                     = JUMP;
      end
      R_MSTATUS: begin
        // mret restores from the live mstatus, not a latched copy
        trap_csrf_we                = 1'b1;
        trap_csrf_write_addr        = CSR_ADDR_WIDTH'(12'h300);
        trap_csrf_write_data        = csrf_all_mstatus_data;
        trap_csrf_write_data[3]     = csrf_all_mstatus_data[7];
        trap_csrf_write_data[7]     = 1'b1;
        trap_csrf_write_data[12:11] = 2'b11;
        state_d                     = JUMP;
      end
      JUMP: begin
        trap_fetch_jump = 1'b1;
        if (mret_q)
          trap_fetch_jump_pc = csrf_all_mepc_data;
        else if (int_q && (mtvec_q[1:0] == 2'b01))
          trap_fetch_jump_pc = mtvec_base + W'({code_q, 2'b00});
        else
          trap_fetch_jump_pc = mtvec_base;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      epc_q     <= '0;
      cause_q   <= '0;
      tval_q    <= '0;
      mtvec_q   <= '0;
      mstatus_q <= '0;
      code_q    <= '0;
      int_q     <= 1'b0;
      mret_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      epc_q     <= epc_d;
      cause_q   <= cause_d;
      tval_q    <= tval_d;
      mtvec_q   <= mtvec_d;
      mstatus_q <= mstatus_d;
      code_q    <= code_d;
      int_q     <= int_d;
      mret_q    <= mret_d;
    end
  end
endmodule

// File: tb/tb_csr_trap_sequencer.sv
// Vector table of trap/interrupt/mret scenarios; expected CSR writes and jumps are
// queued per scenario and matched cycle-exactly as the sequencer emits them.
module tb_csr_trap_sequencer;
  logic        clk = 1'b0;
  logic        rst;
  logic        commit_trap_req, commit_mret_req, commit_int_allow;
  logic [31:0] commit_trap_cause, commit_trap_pc, commit_trap_tval, commit_int_pc;
  logic [31:0] csrf_all_mie_data, csrf_all_mip_data, csrf_all_mstatus_data, csrf_all_mepc_data;
  logic [11:0] trap_csrf_read_addr, trap_csrf_write_addr;
  logic [31:0] csrf_trap_read_data, trap_csrf_write_data, trap_fetch_jump_pc;
  logic        trap_csrf_we, trap_commit_busy, trap_fetch_jump;

  always #5 clk = ~clk;

  csr_trap_sequencer #(.CSR_ADDR_WIDTH(12), .REG_DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .commit_trap_req(commit_trap_req), .commit_trap_cause(commit_trap_cause),
    .commit_trap_pc(commit_trap_pc), .commit_trap_tval(commit_trap_tval),
    .commit_mret_req(commit_mret_req), .commit_int_allow(commit_int_allow),
    .commit_int_pc(commit_int_pc),
    .csrf_all_mie_data(csrf_all_mie_data), .csrf_all_mip_data(csrf_all_mip_data),
    .csrf_all_mstatus_data(csrf_all_mstatus_data), .csrf_all_mepc_data(csrf_all_mepc_data),
    .trap_csrf_read_addr(trap_csrf_read_addr), .csrf_trap_read_data(csrf_trap_read_data),
    .trap_csrf_write_addr(trap_csrf_write_addr), .trap_csrf_write_data(trap_csrf_write_data),
    .trap_csrf_we(trap_csrf_we), .trap_commit_busy(trap_commit_busy),
    .trap_fetch_jump(trap_fetch_jump), .trap_fetch_jump_pc(trap_fetch_jump_pc)
  );

  typedef struct {
    logic        trap, mret, hold, allow;
    logic [31:0] cause, pc, tval, ipc, mie, mip, ms, mepc, mtvec;
    int          n;
    logic [31:0] e_epc, e_cause, e_tval, e_ms, e_jpc;
  } vec_t;

  typedef struct {
    int          cyc;
    logic        jmp;
    logic [11:0] addr;
    logic [31:0] data;
  } ev_t;

  vec_t vecs[$];
  ev_t  sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  task automatic push_ev(input int c, input logic j, input logic [11:0] a, input logic [31:0] d);
    ev_t e;
    e.cyc = c; e.jmp = j; e.addr = a; e.data = d;
    sb.push_back(e);
  endtask

  task automatic step();
    ev_t e;
    @(posedge clk);
    #1;
    cyc++;
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      e = sb.pop_front();
      checks++; errors++;
      $display("FAIL missing_event cyc=%0d got nothing required jump=%0b addr=%h data=%h at cyc %0d",
               cyc, e.jmp, e.addr, e.data, e.cyc);
    end
    if (trap_csrf_we) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write cyc=%0d got addr=%h data=%h required none",
                 cyc, trap_csrf_write_addr, trap_csrf_write_data);
      end else begin
        e = sb.pop_front();
        if (e.jmp || e.cyc != cyc || e.addr != trap_csrf_write_addr || e.data != trap_csrf_write_data) begin
          errors++;
          $display("FAIL csr_write cyc=%0d got addr=%h data=%h required cyc=%0d jump=%0b addr=%h data=%h",
                   cyc, trap_csrf_write_addr, trap_csrf_write_data, e.cyc, e.jmp, e.addr, e.data);
        end
      end
    end
    if (trap_fetch_jump) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_jump cyc=%0d got pc=%h required none", cyc, trap_fetch_jump_pc);
      end else begin
        e = sb.pop_front();
        if (!e.jmp || e.cyc != cyc || e.data != trap_fetch_jump_pc) begin
          errors++;
          $display("FAIL jump cyc=%0d got pc=%h required cyc=%0d jump=%0b pc=%h",
                   cyc, trap_fetch_jump_pc, e.cyc, e.jmp, e.data);
        end
      end
    end
    checks++;
    if ((!trap_csrf_we && (trap_csrf_write_addr != '0 || trap_csrf_write_data != '0)) ||
        (!trap_fetch_jump && trap_fetch_jump_pc != '0)) begin
      errors++;
      $display("FAIL idle_zero cyc=%0d got addr=%h data=%h jpc=%h required 0",
               cyc, trap_csrf_write_addr, trap_csrf_write_data, trap_fetch_jump_pc);
    end
  endtask

  task automatic apply(input vec_t v);
    commit_trap_req       = v.trap;
    commit_trap_cause     = v.cause;
    commit_trap_pc        = v.pc;
    commit_trap_tval      = v.tval;
    commit_mret_req       = v.mret;
    commit_int_allow      = v.allow;
    commit_int_pc         = v.ipc;
    csrf_all_mie_data     = v.mie;
    csrf_all_mip_data     = v.mip;
    csrf_all_mstatus_data = v.ms;
    csrf_all_mepc_data    = v.mepc;
    csrf_trap_read_data   = v.mtvec;
  endtask

  task automatic check_busy(input int id, input logic exp);
    checks++;
    if (trap_commit_busy !== exp) begin
      errors++;
      $display("FAIL busy vec=%0d cyc=%0d got %0b required %0b", id, cyc, trap_commit_busy, exp);
    end
  endtask

  task automatic check_drained(input int id);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drained vec=%0d got %0d pending events required 0", id, sb.size());
      sb.delete();
    end
  endtask

  initial begin
    // trap, mret, hold_mret, allow, cause, pc, tval, int_pc, mie, mip, mstatus, mepc, mtvec,
    //   nwrites, exp_epc, exp_cause, exp_tval, exp_mstatus, exp_jump_pc
    vecs.push_back('{1,0,0,0, 'h2,'h100,'hdead,0, 0,0,'h8,0,'h8000,
                     4, 'h100,'h2,'hdead,'h1880,'h8000});
    vecs.push_back('{0,0,0,1, 0,0,'hbeef,'h200, 'h888,'h880,'h8,0,'h8001,
                     4, 'h200,'h8000000b,0,'h1880,'h802c});
    vecs.push_back('{0,1,0,0, 0,0,0,0, 0,0,'h1880,'h104,0,
                     1, 0,0,0,'h1888,'h104});
    vecs.push_back('{1,1,1,0, 'h5,'h300,'h11,0, 0,0,'h0,'h999,'h4003,
                     4, 'h300,'h5,'h11,'h1800,'h4000});
    vecs.push_back('{1,0,0,1, 'h7,'h400,0,'h600, 'h888,'h888,'h8,0,'h8001,
                     4, 'h400,'h7,0,'h1880,'h8000});
    vecs.push_back('{0,0,0,1, 0,0,0,'h200, 'h888,'h888,'h0,0,'h8001,
                     0, 0,0,0,0,0});
    vecs.push_back('{0,0,0,0, 0,0,0,'h200, 'h888,'h888,'h8,0,'h8001,
                     0, 0,0,0,0,0});
    vecs.push_back('{0,0,0,1, 0,0,0,'h700, 'h888,'h088,'h2008,0,'h1001,
                     4, 'h700,'h80000003,0,'h3880,'h100c});
    vecs.push_back('{0,0,0,1, 0,0,0,'h800, 'h080,'h0a0,'h8,0,'h2000,
                     4, 'h800,'h80000007,0,'h1880,'h2000});
    vecs.push_back('{0,0,0,1, 0,0,0,'h44, 'h800,'h800,'h8,0,'hfffffffd,
                     4, 'h44,'h8000000b,0,'h1880,'h28});
    vecs.push_back('{0,1,0,1, 0,0,0,'h500, 'h8,'h8,'h8,'h123,'h3001,
                     4, 'h500,'h80000003,0,'h1880,'h300c});
    vecs.push_back('{0,1,0,0, 0,0,0,0, 0,0,'h8,'hfffffff0,0,
                     1, 0,0,0,'h1880,'hfffffff0});

    apply('{0,0,0,0, 0,0,0,0, 0,0,0,0,0, 0, 0,0,0,0,0});
    rst = 1'b1;
    step();
    step();
    check_busy(-1, 1'b0);
    checks++;
    if (trap_csrf_we || trap_fetch_jump || trap_csrf_read_addr != 12'h305) begin
      errors++;
      $display("FAIL reset_state got we=%0b jump=%0b raddr=%h required 0 0 305",
               trap_csrf_we, trap_fetch_jump, trap_csrf_read_addr);
    end
    rst = 1'b0;
    step();

    foreach (vecs[i]) begin
      int base;
      apply(vecs[i]);
      base = cyc;
      if (vecs[i].n == 4) begin
        push_ev(base + 1, 1'b0, 12'h341, vecs[i].e_epc);
        push_ev(base + 2, 1'b0, 12'h342, vecs[i].e_cause);
        push_ev(base + 3, 1'b0, 12'h343, vecs[i].e_tval);
        push_ev(base + 4, 1'b0, 12'h300, vecs[i].e_ms);
        push_ev(base + 5, 1'b1, 12'h000, vecs[i].e_jpc);
      end else if (vecs[i].n == 1) begin
        push_ev(base + 1, 1'b0, 12'h300, vecs[i].e_ms);
        push_ev(base + 2, 1'b1, 12'h000, vecs[i].e_jpc);
      end
      for (int k = 1; k <= 7; k++) begin
        step();
        if (k == 1) begin
          commit_trap_req  = 1'b0;
          commit_int_allow = 1'b0;
          if (!vecs[i].hold) commit_mret_req = 1'b0;
        end
        if (k == 5) commit_mret_req = 1'b0;
        check_busy(i, (vecs[i].n == 4) ? (k <= 5) : (vecs[i].n == 1) ? (k <= 2) : 1'b0);
      end
      check_drained(i);
    end

    // reset while the mcause write is on the bus: sequence must die silently
    apply(vecs[0]);
    push_ev(cyc + 1, 1'b0, 12'h341, vecs[0].e_epc);
    push_ev(cyc + 2, 1'b0, 12'h342, vecs[0].e_cause);
    step();
    commit_trap_req = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_busy(100, 1'b0);
    checks++;
    if (trap_csrf_we || trap_fetch_jump) begin
      errors++;
      $display("FAIL reset_abort got we=%0b jump=%0b required 0 0", trap_csrf_we, trap_fetch_jump);
    end
    for (int k = 0; k < 6; k++) begin
      step();
      check_busy(100, 1'b0);
    end
    check_drained(100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/csr_trap_sequencer.md
CSR_TRAP_SEQUENCER -- requirements
Module: csr_trap_sequencer

Interface
REQ-001 SHALL have parameter CSR_ADDR_WIDTH, default 12, CSR address width.
REQ-002 SHALL have parameter REG_DATA_WIDTH, default 32, CSR data width.
REQ-003 SHALL have one clock and synchronous active-high reset, with ports listed first:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- commit_trap_req  in  1  exception at commit
- commit_trap_cause  in  REG_DATA_WIDTH  exception mcause value
- commit_trap_pc  in  REG_DATA_WIDTH  faulting PC
- commit_trap_tval  in  REG_DATA_WIDTH  mtval value
- commit_mret_req  in  1  mret committed
- commit_int_allow  in  1  commit at instruction boundary; interrupt may be taken
- commit_int_pc  in  REG_DATA_WIDTH  next PC for interrupt
- csrf_all_mie_data / csrf_all_mip_data / csrf_all_mstatus_data / csrf_all_mepc_data  in  REG_DATA_WIDTH each  csrfile live values
- trap_csrf_read_addr  out  CSR_ADDR_WIDTH  constant 0x305 (mtvec)
- csrf_trap_read_data  in  REG_DATA_WIDTH  combinational read of mtvec
- trap_csrf_write_addr  out  CSR_ADDR_WIDTH  CSR write address
- trap_csrf_write_data  out  REG_DATA_WIDTH  CSR write data
- trap_csrf_we  out  1  CSR write enable
- trap_commit_busy  out  1  sequence in progress
- trap_fetch_jump  out  1  one-cycle redirect pulse
- trap_fetch_jump_pc  out  REG_DATA_WIDTH  redirect target

Function
REQ-004 FSM states SHALL be IDLE, W_MEPC, W_MCAUSE, W_MTVAL, W_MSTATUS, R_MSTATUS, JUMP.
REQ-005 Requests SHALL be sampled only in IDLE; requests in other states are ignored.
REQ-006 Priority in IDLE SHALL be: commit_trap_req > interrupt > commit_mret_req.
REQ-007 Interrupt SHALL be pending when commit_int_allow && mstatus[3] && |(mie & mip & 0x888).
REQ-008 Interrupt cause SHALL be 0x80000000 | code: code 11 (MEI) > 3 (MSI) > 7 (MTI).
REQ-009 On trap or interrupt acceptance, SHALL latch epc, cause, tval (0 for interrupts), mtvec and mstatus; go to W_MEPC.
REQ-010 W_MEPC, W_MCAUSE, W_MTVAL SHALL each assert we for one cycle, address 0x341/0x342/0x343, latched data, in that order.
REQ-011 W_MSTATUS SHALL write 0x300: latched mstatus with MPIE[7]=old MIE[3], MIE[3]=0, MPP[12:11]=2'b11; then JUMP.
REQ-012 On mret acceptance, SHALL go to R_MSTATUS: write 0x300 with MIE[3]=live MPIE[7], MPIE[7]=1, MPP=2'b11; then JUMP.
REQ-013 JUMP SHALL pulse trap_fetch_jump for one cycle; next state IDLE.
REQ-014 Jump target: mret -> csrf_all_mepc_data at JUMP; trap -> {mtvec[31:2],2'b00}; interrupt with mtvec[1:0]==1 -> base + 4*code.
REQ-015 Latency SHALL be: trap accepted cycle 0, we cycles 1-4, jump cycle 5; mret accepted cycle 0, we cycle 1, jump cycle 2.
REQ-016 trap_commit_busy SHALL be 1 in every non-IDLE state, 0 in IDLE.
REQ-017 In IDLE and JUMP, we=0 and write_addr/write_data=0; jump_pc=0 except in JUMP.
REQ-018 Target arithmetic SHALL wrap modulo 2^REG_DATA_WIDTH.

Reset
REQ-019 rst SHALL force IDLE, clear all latches, and drive we, busy, jump and all data outputs to 0 at the next edge.
REQ-020 Reset mid-sequence SHALL abort with no further writes or jump pulse.

Verification
REQ-021 Trap: cause 2, pc 0x100, tval 0xdead, mtvec 0x8000, mstatus 0x8 -> writes 0x341=0x100, 0x342=2, 0x343=0xdead, 0x300=0x1880 in cycles 1-4; jump to 0x8000 at cycle 5.
REQ-022 Interrupt: mstatus 0x8, mie 0x888, mip 0x880, allow=1, pc 0x200, mtvec 0x8001 -> cause 0x8000000B, tval 0, jump 0x802C.
REQ-023 Mret: mstatus 0x1880, mepc 0x104 -> single write 0x300=0x1888; jump 0x104 at cycle 2.
REQ-024 Trap and mret in the same cycle -> trap sequence only; mret held during busy is ignored.
REQ-025 Interrupt masked (mstatus[3]=0 or allow=0) -> stays IDLE, no write.
REQ-026 rst asserted in W_MCAUSE -> next cycle IDLE, we=0, busy=0, no jump.
